ds_upsize: RTL and testbench
============================

# ds_upsize

Data-stream width upsizer placed directly upstream of `ds_fifo`. It packs `RATIO` consecutive narrow beats into one wide word so the FIFO stores full-width entries. A packet end (`i_last`) flushes a partial word, marked by a lane-keep mask. Both sides use valid/ready bidirectional flow control, and the block sustains one narrow beat per cycle.

## Interface
Parameters:
- `DW`, 8, narrow beat width in bits (≥1)
- `RATIO`, 4, narrow beats per wide word (≥2); derived `ODW = DW*RATIO`, `CW = $clog2(RATIO)`

Ports:
- `i_clk`  in  1  clock; all logic on rising edge
- `i_rst`  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous release externally guaranteed
- `i_vld`  in  1  narrow beat valid
- `o_rdy`  out  1  narrow beat ready
- `i_dat`  in  DW  narrow beat data
- `i_last`  in  1  beat is last of packet
- `o_vld`  out  1  wide word valid
- `i_rdy`  in  1  wide word ready (from FIFO write side)
- `o_dat`  out  ODW  wide word data
- `o_keep`  out  RATIO  lane k holds valid data
- `o_last`  out  1  word closes a packet

## Operation
- Narrow handshake `acc = i_vld & o_rdy`. Wide handshake `wr = o_vld & i_rdy`.
- `o_rdy = i_rst & (!o_vld | i_rdy)`. It is combinational on `i_rdy` only and never depends on `i_vld`/`i_last`. It is 0 while in reset.
- Internal state:
  - Lane counter `cnt[CW-1:0]`.
  - Accumulator `acc_dat[ODW-1:0]` with `acc_keep[RATIO-1:0]`.
  - Output register holding `o_dat/o_keep/o_last/o_vld`.
- On `acc`, the beat is written to lane `cnt`, bits `[cnt*DW +: DW]`. Little-endian: the first beat lands in the LSBs.
- Completion: `acc & (cnt == RATIO-1 | i_last)`. On completion:
  - The output register loads the merged accumulator plus the current beat.
  - `o_keep` gets the lanes `0..cnt` set.
  - `o_last = i_last`, `o_vld = 1`.
  - `cnt`, `acc_dat` and `acc_keep` clear to 0.
- Non-completing `acc`: the beat is stored and `cnt` increments.
- Unfilled lanes of a partial word output as 0; the keep bits are contiguous from lane 0.
- `o_vld` clears on `wr` unless a completion happens in the same cycle. In that case the new word loads and `o_vld` stays 1, giving back-to-back words.
- While `o_vld & !i_rdy`, `o_dat/o_keep/o_last` are held stable and no narrow beat is accepted.
- `i_last` on lane `RATIO-1` produces a full keep mask with `o_last = 1`. `i_last` on lane 0 produces `o_keep = 'b0…01`.
- Inputs are ignored when `i_vld = 0`. The upstream side must hold `i_dat/i_last` stable until `acc`; a violation is not detected.
- Reset values, asserted asynchronously when `i_rst = 0`: `o_vld = 0`, `o_dat = 0`, `o_keep = 0`, `o_last = 0`, `cnt = 0`, accumulator 0, `o_rdy = 0`. After release, `o_rdy = 1`.
- Reset mid-packet discards the partial accumulator and any pending output word with no flush.

## Timing
- Latency: the word is visible (`o_vld = 1`) the cycle after the completing beat's `acc` edge.
- Throughput:
  - 1 narrow beat per cycle while `i_rdy = 1`, i.e. 1 wide word per `RATIO` cycles for full words.
  - 1 wide word per cycle for single-beat packets when `i_rdy = 1`.
- Stall: `i_rdy = 0` with `o_vld = 1` forces `o_rdy = 0` in the same cycle. `i_rdy` rising re-asserts `o_rdy` in the same cycle.
- No combinational path from `i_vld`/`i_dat`/`i_last` to any output. `o_rdy` depends combinationally on `i_rdy` and registered `o_vld` only.

## Test plan
- Basic packing, `DW = 8`, `RATIO = 4`, `i_rdy = 1`: send beats 0x11, 0x22, 0x33, 0x44 (last on 0x44) on consecutive cycles. Expect one word `o_dat = 0x44332211`, `o_keep = 4'b1111`, `o_last = 1`, `o_vld` high for exactly 1 cycle, the cycle after the 4th beat.
- Partial flush: send 0xA1, 0xA2 with last on 0xA2. Expect `o_dat = 0x0000A2A1`, `o_keep = 4'b0011`, `o_last = 1`, `cnt` back to 0. The next beat 0xB0 lands in lane 0.
- Single-beat packets back-to-back: 4 beats, each with `i_last = 1`, `i_rdy = 1`. Expect 4 consecutive words with `o_keep = 4'b0001` and no bubbles.
- Backpressure: hold `i_rdy = 0` while word 0x44332211 is pending, and present 0x55 upstream. Expect `o_rdy = 0` and the output word frozen for 5 cycles. After `i_rdy = 1`, expect 0x55 accepted that cycle and the word consumed.
- Reset mid-packet: accept 0x01, 0x02, then pull `i_rst` low for 2 cycles. Expect all outputs 0 immediately (asynchronous) and `o_rdy = 0`. After release, send 0x03, 0x04, 0x05, 0x06 (last on 0x06). Expect `o_dat = 0x06050403`.
- Random soak, 10k beats, random `i_vld`/`i_rdy`/`i_last`: the scoreboard repacks the narrow stream and must match wide words exactly, with no handshake rule violations.

Source files
------------

// File: rtl/ds_upsize.sv
// ds_upsize: data-stream width upsizer.
//
// Packs RATIO consecutive DW-bit narrow beats into one ODW-bit wide word,
// little-endian: the first beat of a word lands in lane 0 (the LSBs).
// A beat with i_last closes the word early. Lanes that were not filled
// read as zero, and o_keep marks the filled lanes, which always run
// contiguously from lane 0.
//
// Ports
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-low reset
//   i_vld   narrow beat valid            o_rdy   narrow beat ready
//   i_dat   narrow beat data [DW]        i_last  beat closes the packet
//   o_vld   wide word valid              i_rdy   wide word ready
//   o_dat   wide word data [ODW]         o_keep  per-lane valid mask [RATIO]
//   o_last  wide word closes the packet
//
// o_rdy depends only on the registered o_vld and on i_rdy. There is no
// combinational path from i_vld, i_dat or i_last to any output.
module ds_upsize #(
  parameter  int DW    = 8,
  parameter  int RATIO = 4,
  localparam int ODW   = DW * RATIO,
  localparam int CW    = $clog2(RATIO)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [DW-1:0]    i_dat,
  input  logic             i_last,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [ODW-1:0]   o_dat,
  output logic [RATIO-1:0] o_keep,
  output logic             o_last
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ODW-1:0]   acc_dat_q, acc_dat_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic [ODW-1:0]   out_dat_q, out_dat_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_vld_q, out_vld_d;

  logic             acc;
  logic             wr;
  logic             done;
  logic [ODW-1:0]   merged_dat;
  logic [RATIO-1:0] merged_keep;

  // An empty or draining output register can take a new word, so a beat
  // (possibly a completing one) is acceptable in the same cycle.
  assign o_rdy = i_rst & (~out_vld_q | i_rdy);
  assign acc   = i_vld & o_rdy;
  assign wr    = out_vld_q & i_rdy;
  assign done  = acc & ((cnt_q == CW'(RATIO - 1)) | i_last);

  always_comb begin
    // Accumulator with the current beat dropped into lane cnt. Because
    // acc_keep is always contiguous from lane 0, OR-ing in lane cnt yields
    // exactly lanes 0..cnt.
    merged_dat  = acc_dat_q;
    merged_keep = acc_keep_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        merged_dat[k*DW +: DW] = i_dat;
        merged_keep[k]         = 1'b1;
      end
    end

    cnt_d      = cnt_q;
    acc_dat_d  = acc_dat_q;
    acc_keep_d = acc_keep_q;
    out_dat_d  = out_dat_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;

    if (wr) begin
      out_vld_d = 1'b0;
    end

    // A completion in the same cycle as a drain reloads the register and
    // keeps o_vld high, giving back-to-back words.
    if (acc) begin
      if (done) begin
        out_dat_d  = merged_dat;
        out_keep_d = merged_keep;
        out_last_d = i_last;
        out_vld_d  = 1'b1;
        cnt_d      = '0;
        acc_dat_d  = '0;
        acc_keep_d = '0;
      end else begin
        acc_dat_d  = merged_dat;
        acc_keep_d = merged_keep;
        cnt_d      = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q      <= '0;
      acc_dat_q  <= '0;
      acc_keep_q <= '0;
      out_dat_q  <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_dat_q  <= acc_dat_d;
      acc_keep_q <= acc_keep_d;
      out_dat_q  <= out_dat_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign o_vld  = out_vld_q;
  assign o_dat  = out_dat_q;
  assign o_keep = out_keep_q;
  assign o_last = out_last_q;

endmodule

// File: tb/tb_ds_upsize.sv
// Self-checking bench for ds_upsize (DW=8, RATIO=4): directed vector table,
// hand-written reset and drain sequences, and a random soak with a
// repacking scoreboard.
module tb_ds_upsize;

  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int ODW   = DW * RATIO;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_vld = 1'b0;
  logic [DW-1:0]    i_dat = '0;
  logic             i_last = 1'b0;
  logic             i_rdy = 1'b0;
  logic             o_rdy;
  logic             o_vld;
  logic [ODW-1:0]   o_dat;
  logic [RATIO-1:0] o_keep;
  logic             o_last;

  ds_upsize #(.DW(DW), .RATIO(RATIO)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_vld (i_vld),
    .o_rdy (o_rdy),
    .i_dat (i_dat),
    .i_last(i_last),
    .o_vld (o_vld),
    .i_rdy (i_rdy),
    .o_dat (o_dat),
    .o_keep(o_keep),
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        last;
    logic        rdy;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic [3:0]  e_keep;
    logic        e_last;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic last,
                              input logic rdy, input logic e_rdy, input logic e_vld,
                              input logic [31:0] e_dat, input logic [3:0] e_keep,
                              input logic e_last);
    vec_t v;
    v.vld = vld; v.dat = dat; v.last = last; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_keep = e_keep; v.e_last = e_last;
    return v;
  endfunction

  typedef struct {
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  vec_t  vt[$];
  word_t sb[$];

  initial begin
    // ---------------- directed vector table ----------------
    // Expected outputs are those seen during the cycle the inputs are driven.
    // basic packing
    vt.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'h44, 1, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h44332211, 4'hF, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    // partial flush, next beat lands in lane 0
    vt.push_back(mk(1, 8'hA1, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'hA2, 1, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'hB0, 0, 1, 1, 1, 32'h0000A2A1, 4'h3, 1));
    vt.push_back(mk(1, 8'hB1, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'hB2, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'hB3, 1, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'hB3B2B1B0, 4'hF, 1));
    // single-beat packets back to back
    vt.push_back(mk(1, 8'h01, 1, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'h02, 1, 1, 1, 1, 32'h00000001, 4'h1, 1));
    vt.push_back(mk(1, 8'h03, 1, 1, 1, 1, 32'h00000002, 4'h1, 1));
    vt.push_back(mk(1, 8'h04, 1, 1, 1, 1, 32'h00000003, 4'h1, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h00000004, 4'h1, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    // backpressure: word pending, 0x55 offered, 5 stalled cycles
    vt.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(1, 8'h44, 1, 1, 1, 0, 32'h0, 4'h0, 0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1, 8'h55, 1, 0, 0, 1, 32'h44332211, 4'hF, 1));
    vt.push_back(mk(1, 8'h55, 1, 1, 1, 1, 32'h44332211, 4'hF, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h00000055, 4'h1, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
    // completion while downstream not ready but register empty
    vt.push_back(mk(1, 8'h66, 1, 0, 1, 0, 32'h0, 4'h0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h00000066, 4'h1, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h00000066, 4'h1, 1));
    vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));

    // ---------------- reset values ----------------
    i_rdy = 1'b1;
    #2;
    chk("rst_o_rdy", o_rdy, 0);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o_dat", o_dat, 0);
    chk("rst_o_keep", o_keep, 0);
    chk("rst_o_last", o_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_o_rdy", o_rdy, 1);

    // ---------------- apply vector table ----------------
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      i_vld  = vt[i].vld;
      i_dat  = vt[i].dat;
      i_last = vt[i].last;
      i_rdy  = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_o_rdy", i), o_rdy, vt[i].e_rdy);
      chk($sformatf("v%0d_o_vld", i), o_vld, vt[i].e_vld);
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d_o_dat", i), o_dat, vt[i].e_dat);
        chk($sformatf("v%0d_o_keep", i), o_keep, vt[i].e_keep);
        chk($sformatf("v%0d_o_last", i), o_last, vt[i].e_last);
      end
    end

    // ---------------- reset mid-packet ----------------
    @(posedge clk); #1;
    i_vld = 1'b1; i_dat = 8'h01; i_last = 1'b0; i_rdy = 1'b1;
    @(posedge clk); #1;
    i_dat = 8'h02;
    @(posedge clk); #1;
    i_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_vld", o_vld, 0);
    chk("mid_rst_o_dat", o_dat, 0);
    chk("mid_rst_o_keep", o_keep, 0);
    chk("mid_rst_o_last", o_last, 0);
    chk("mid_rst_o_rdy", o_rdy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 3; b <= 6; b++) begin
      @(posedge clk); #1;
      i_vld = 1'b1; i_dat = 8'(b); i_last = (b == 6);
    end
    @(posedge clk); #1;
    i_vld = 1'b0; i_last = 1'b0;
    @(negedge clk);
    chk("after_rst_o_vld", o_vld, 1);
    chk("after_rst_o_dat", o_dat, 32'h06050403);
    chk("after_rst_o_keep", o_keep, 4'hF);
    chk("after_rst_o_last", o_last, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_rst_drained", o_vld, 0);

    // ---------------- random soak ----------------
    begin
      logic [31:0] b_dat;
      logic [3:0]  b_keep;
      int unsigned b_cnt;
      int          acc_n;
      int          cyc;
      logic        pend;
      logic        hold;
      logic [31:0] h_dat;
      logic [3:0]  h_keep;
      logic        h_last;
      word_t       w;
      b_dat = '0; b_keep = '0; b_cnt = 0; acc_n = 0; cyc = 0;
      pend = 1'b0; hold = 1'b0; h_dat = '0; h_keep = '0; h_last = 1'b0;
      while (acc_n < 10000 && cyc < 60000) begin
        @(posedge clk); #1;
        if (!pend) begin
          i_vld  = ($urandom_range(0, 3) != 0);
          i_dat  = 8'($urandom);
          i_last = ($urandom_range(0, 3) == 0);
        end
        i_rdy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        cyc++;
        if (hold) begin
          chk("stall_o_vld", o_vld, 1);
          chk("stall_o_dat", o_dat, h_dat);
          chk("stall_o_keep", o_keep, h_keep);
          chk("stall_o_last", o_last, h_last);
        end
        chk("rdy_rule", o_rdy, !o_vld || i_rdy);
        chk("vld_vs_scoreboard", o_vld, sb.size() != 0);
        if (o_vld && i_rdy && sb.size() != 0) begin
          w = sb.pop_front();
          chk("soak_o_dat", o_dat, w.dat);
          chk("soak_o_keep", o_keep, w.keep);
          chk("soak_o_last", o_last, w.last);
        end
        hold   = o_vld && !i_rdy;
        h_dat  = o_dat;
        h_keep = o_keep;
        h_last = o_last;
        if (i_vld && o_rdy) begin
          acc_n++;
          b_dat  = b_dat | (32'(i_dat) << (b_cnt * 8));
          b_keep = b_keep | (4'b0001 << b_cnt);
          if (b_cnt == 3 || i_last) begin
            w.dat = b_dat; w.keep = b_keep; w.last = i_last;
            sb.push_back(w);
            b_dat = '0; b_keep = '0; b_cnt = 0;
          end else begin
            b_cnt++;
          end
          pend = 1'b0;
        end else begin
          pend = i_vld;
        end
      end
      chk("soak_beats_done", acc_n, 10000);
      // drain any pending word
      @(posedge clk); #1;
      i_vld = 1'b0; i_rdy = 1'b1;
      @(negedge clk);
      if (o_vld && sb.size() != 0) begin
        w = sb.pop_front();
        chk("drain_o_dat", o_dat, w.dat);
        chk("drain_o_keep", o_keep, w.keep);
        chk("drain_o_last", o_last, w.last);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("drain_o_vld", o_vld, 0);
      chk("drain_scoreboard_empty", sb.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
